// File: rtl/uart_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit/receive blocks.
//            Holds the line-state enumeration (PARITY always present so the
//            encoding is identical whether or not parity is built in), the
//            data width of a character and the 48 MHz / 115200 baud divisor.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int UART_DATA_BITS               = 8;
    localparam int UART_CLKS_PER_BIT_48M_115200 = 417;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Purpose  : Small synchronous circular-buffer FIFO, first-word fall-through
//            (o_data always shows the oldest entry while not empty).
// Ports    : i_clk    clock
//            i_rst_n  synchronous reset, active-low (empties the queue)
//            i_push   write i_data (ignored while full)
//            i_pop    discard oldest entry (ignored while empty)
//            i_data   write data
//            o_data   oldest entry
//            o_full   count == DEPTH
//            o_empty  count == 0
//            o_count  number of stored entries
// Params   : WIDTH data width, DEPTH entries (power of two, >= 2)
// Revision : 1.0  initial release
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                 c_addr_w  = $clog2(DEPTH);
    localparam logic [c_addr_w-1:0] c_ptr_one = 1;
    localparam logic [c_addr_w:0]   c_cnt_one = 1;
    localparam logic [c_addr_w:0]   c_depth   = (c_addr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_push;
    logic                w_pop;

    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            if (w_push && !w_pop)      r_count <= r_count + c_cnt_one;
            else if (w_pop && !w_push) r_count <= r_count - c_cnt_one;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule : uart_fifo
`default_nettype wire

// File: rtl/uart_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Buffered UART transmitter. Bytes enter through a valid/ready
//            handshake, wait in a small FIFO and are sent LSB-first as 8N1
//            frames (8E1 when UART_TX_PARITY_EN is defined). Queued bytes are
//            sent back-to-back with no idle gap between frames.
// Ports    : i_clk    system clock
//            i_rst_n  synchronous reset, active-low; aborts any frame
//            i_data   byte to transmit
//            i_valid  i_data is valid
//            o_ready  queue can accept a byte (not full)
//            o_tx     serial line, idle high, registered
//            o_busy   frame in progress or queue non-empty
// Params   : CLKS_PER_BIT clocks per bit (>= 2), FIFO_DEPTH queue entries
// Macro    : UART_TX_PARITY_EN  adds an even-parity bit before the stop bit
// Revision : 1.0  initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_48M_115200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [UART_DATA_BITS-1:0] i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic                      o_tx,
    output logic                      o_busy
);

    localparam int                  c_baud_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_one = 1;
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          c_bit_last = 3'(UART_DATA_BITS - 1);

    uart_state_t               r_state;
    logic [c_baud_w-1:0]       r_baud;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;
`ifdef UART_TX_PARITY_EN
    logic                      r_parity;
`endif

    logic [UART_DATA_BITS-1:0]     w_fifo_data;
    logic                          w_full;
    logic                          w_empty;
    logic [$clog2(FIFO_DEPTH):0]   w_count;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_bit_end;

    assign w_bit_end = (r_baud == c_baud_last);
    assign o_ready   = !w_full;
    assign w_push    = i_valid && o_ready;
    // A new byte is taken either from idle or on the final cycle of the stop
    // bit, which is what makes consecutive frames contiguous.
    assign w_pop     = !w_empty && ((r_state == IDLE) ||
                                    ((r_state == STOP) && w_bit_end));
    assign o_busy    = (r_state != IDLE) || (w_count != '0);
    assign o_tx      = r_tx;

    uart_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_data),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            // Baud counter is parked at 0 while idle so a frame always
            // starts with a full-length start bit.
            if ((r_state == IDLE) || w_bit_end) r_baud <= '0;
            else                                r_baud <= r_baud + c_baud_one;

            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_state <= START;
                        r_tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_fifo_data;
`endif
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == c_bit_last) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            // Next bit is shift[1]; drive it now so o_tx
                            // stays a pure register output.
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
`ifdef UART_TX_PARITY_EN
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
`else
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
`endif
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= w_fifo_data;
                            r_state <= START;
                            r_tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_fifo_data;
`endif
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx (CLKS_PER_BIT = 4, depth 4).
//            The serial line is logged every cycle; a behavioural receiver
//            finds frames in the log and compares bytes and the full frame
//            waveform against the expected byte stream.
// Macro    : UART_TX_PARITY_EN  enables the 8E1 expectations and parity tests
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;
    localparam int LOG   = 8192;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready),
        .o_tx    (tx),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; log[c] = outputs after edge c.
    int   cyc = 0;
    logic tx_log   [LOG];
    logic busy_log [LOG];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cyc < LOG) begin
            tx_log[cyc]   <= tx;
            busy_log[cyc] <= busy;
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected line level t cycles after start-bit onset for byte b.
    function automatic logic exp_level(input logic [7:0] b, input int t);
        int k;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    int         f_start [$];
    logic [7:0] f_byte  [$];

    // Behavioural receiver: a low level marks a start bit; bits are read
    // at mid-period and the whole frame is then skipped.
    task automatic scan(input int from, input int to);
        int p;
        logic [7:0] b;
        f_start.delete();
        f_byte.delete();
        p = from;
        while (p + FRAME <= to) begin
            if (tx_log[p] === 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = tx_log[p + (1 + k) * CPB + CPB / 2];
                f_start.push_back(p);
                f_byte.push_back(b);
                p = p + FRAME;
            end else begin
                p = p + 1;
            end
        end
    endtask

    function automatic int start_at(input int i);
        if (i < f_start.size()) return f_start[i];
        return -1000;
    endfunction

    task automatic compare_frames(input string tag, input logic [7:0] expq[$],
                                  input int from, input int to);
        int e;
        scan(from, to);
        check($sformatf("%s frame count", tag), f_start.size(), expq.size());
        for (int i = 0; i < f_start.size() && i < expq.size(); i++) begin
            check($sformatf("%s byte %0d", tag, i), {24'd0, f_byte[i]}, {24'd0, expq[i]});
            e = 0;
            for (int t = 0; t < FRAME; t++)
                if (tx_log[f_start[i] + t] !== exp_level(expq[i], t)) e++;
            check($sformatf("%s waveform %0d", tag, i), e, 0);
        end
    endtask

    // Offer a byte as soon as ready; acc returns the negedge index at
    // which it was presented (accepted on the following rising edge).
    task automatic push(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push ready wait", n < 200, 1);
        acc   = cyc;
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    logic [7:0] q [$];
    int c0, c1, s, acc, hi, gaps, cnt;
    logic [7:0] nxt;
    logic r;

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        tick(3);
        check("reset tx", tx, 1);
        check("reset ready", ready, 1);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        c0 = cyc;
        tick(20);
        cnt = 0;
        for (int i = c0 + 1; i < cyc; i++) if (tx_log[i] !== 1'b1) cnt++;
        check("idle line low cycles", cnt, 0);

        // ---------------- single byte ----------------
        push(8'hA5, c0);
        tick(FRAME + 10);
        q = '{8'hA5};
        compare_frames("single", q, c0, cyc - 1);
        s = start_at(0);
        check("single start latency", s, c0 + 2);
        check("single busy last cycle", busy_log[c0 + 2 + FRAME - 1], 1);
        check("single busy after frame", busy_log[c0 + 2 + FRAME], 0);

        // ---------------- back-to-back ----------------
        push(8'h00, c0);
        push(8'hFF, c1);
        push(8'h55, c1);
        tick(3 * FRAME + 10);
        q = '{8'h00, 8'hFF, 8'h55};
        compare_frames("b2b", q, c0, cyc - 1);
        check("b2b gap 0-1", start_at(1) - start_at(0), FRAME);
        check("b2b gap 1-2", start_at(2) - start_at(1), FRAME);

        // ---------------- full queue ----------------
        c0  = cyc;
        nxt = 8'h10;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            r     = ready;
            valid = 1'b1;
            data  = nxt;
            if (r) begin
                acc++;
                nxt++;
            end
            @(negedge clk);
        end
        check("full acceptances before stall", acc, 5);
        check("full ready low", ready, 0);
        for (int w = 0; w < 4; w++) begin
            hi = 0;
            for (int i = 0; i < FRAME; i++) begin
                r     = ready;
                valid = 1'b1;
                data  = nxt;
                if (r) begin
                    hi++;
                    acc++;
                    nxt++;
                end
                @(negedge clk);
            end
            check($sformatf("full ready pulses window %0d", w), hi, 1);
        end
        valid = 1'b0;
        tick(6 * FRAME);
        q.delete();
        for (int i = 0; i < acc; i++) q.push_back(8'(8'h10 + i));
        compare_frames("full", q, c0, cyc - 1);
        gaps = 0;
        for (int i = 1; i < f_start.size(); i++) if (f_start[i] - f_start[i-1] != FRAME) gaps++;
        check("full non-contiguous frames", gaps, 0);

        // ---------------- reset mid-frame ----------------
        push(8'h3C, c0);
        push(8'h3D, c1);
        s = c0 + 2;
        tick(s + 14 - cyc);
        rst_n = 1'b0;
        tick(1);
        check("midreset frame had started", tx_log[s], 0);
        check("midreset tx", tx, 1);
        check("midreset busy", busy, 0);
        check("midreset ready", ready, 1);
        tick(1);
        rst_n = 1'b1;
        c1 = cyc;
        tick(2 * FRAME);
        cnt = 0;
        hi  = 0;
        for (int i = c1 + 1; i < cyc; i++) begin
            if (tx_log[i] !== 1'b1) cnt++;
            if (busy_log[i] !== 1'b0) hi++;
        end
        check("midreset line low after release", cnt, 0);
        check("midreset busy after release", hi, 0);

        // ---------------- random bytes, random spacing ----------------
        q.delete();
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            nxt = 8'($urandom);
            push(nxt, c1);
            q.push_back(nxt);
            tick($urandom_range(0, 3 * FRAME / 2));
        end
        tick(9 * FRAME);
        compare_frames("random", q, c0, cyc - 1);

`ifdef UART_TX_PARITY_EN
        // ---------------- parity ----------------
        push(8'h07, c0);
        tick(FRAME + 10);
        q = '{8'h07};
        compare_frames("par07", q, c0, cyc - 1);
        s = c0 + 2;
        check("par07 parity bit", tx_log[s + 9 * CPB + CPB / 2], 1);
        check("par07 busy after 44", busy_log[s + 44], 0);
        push(8'h03, c0);
        tick(FRAME + 10);
        q = '{8'h03};
        compare_frames("par03", q, c0, cyc - 1);
        s = c0 + 2;
        check("par03 parity bit", tx_log[s + 9 * CPB + CPB / 2], 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx
`default_nettype wire
